// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtract cell stepped over WIDTH cycles, LSB first.
// Handshake: start accepted in IDLE, busy through RUN/DONE, one-cycle done pulse.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_r, r_diff;
  logic             r_borrow, r_bout;
  logic [CW-1:0]    r_cnt;
  logic             w_d, w_bo, w_last;

  assign w_d    = r_a[0] ^ r_b[0] ^ r_borrow;
  assign w_bo   = (~r_a[0] & r_b[0]) | (~r_a[0] & r_borrow) | (r_b[0] & r_borrow);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = start ? S_RUN : S_IDLE;
      S_RUN:   w_next = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_r      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_a      <= a;
          r_b      <= b;
          r_borrow <= bin;
          r_cnt    <= '0;
        end
        S_RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_r      <= {w_d, r_r[WIDTH-1:1]};
          r_borrow <= w_bo;
          r_cnt    <= r_cnt + 1'b1;
          // Result outputs are captured with the final bit, so they are valid as DONE begins.
          if (w_last) begin
            r_diff <= {w_d, r_r[WIDTH-1:1]};
            r_bout <= w_bo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == S_RUN) || (r_state == S_DONE);
  assign done = (r_state == S_DONE);
  assign diff = r_diff;
  assign bout = r_bout;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: an 8-bit instance for handshake/timing and a 4-bit instance swept exhaustively.
module tb_serial_sub_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic       start4 = 1'b0, bin4 = 1'b0, busy4, done4, bout4;
  logic [3:0] a4 = '0, b4 = '0, diff4;

  logic [8:0] sb8[$];
  logic [4:0] sb4[$];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));

  serial_sub_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4));

  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {8'd0, c};
  endfunction

  function automatic logic [4:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {4'd0, c};
  endfunction

  task automatic launch8(input logic [7:0] x, input logic [7:0] y, input logic c);
    start8 = 1'b1; a8 = x; b8 = y; bin8 = c;
    sb8.push_back(ref8(x, y, c));
  endtask

  task automatic launch4(input logic [3:0] x, input logic [3:0] y, input logic c);
    start4 = 1'b1; a4 = x; b4 = y; bin4 = c;
    sb4.push_back(ref4(x, y, c));
  endtask

  // Waits (bounded) for done on the chosen instance; optionally drops start after the accept edge.
  task automatic wait_done(input bit w4, input bit drop, output bit found, output int cyc, output int nb);
    found = 1'b0; cyc = 0; nb = 0;
    while (!found && cyc < 40) begin
      @(negedge clk);
      if (drop) begin start8 = 1'b0; start4 = 1'b0; end
      cyc++;
      if (w4 ? busy4 : busy8) nb++;
      if (w4 ? done4 : done8) found = 1'b1;
    end
  endtask

  task automatic test_reset;
    #1;
    n_chk++;
    if ({busy8, done8, diff8, bout8} !== 11'd0)
      $display("FAIL reset8 got busy=%b done=%b diff=%h bout=%b exp all 0", busy8, done8, diff8, bout8);
    else n_pass++;
    n_chk++;
    if ({busy4, done4, diff4, bout4} !== 7'd0)
      $display("FAIL reset4 got busy=%b done=%b diff=%h bout=%b exp all 0", busy4, done4, diff4, bout4);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit found; int cyc, nb; logic [8:0] e;
    launch8(8'd5, 8'd3, 1'b0);
    wait_done(1'b0, 1'b1, found, cyc, nb);
    n_chk++;
    if (!found) begin $display("FAIL basic_timeout got no done exp done"); return; end
    else n_pass++;
    e = sb8.pop_front();
    n_chk++;
    if (cyc !== 9) $display("FAIL basic_latency got %0d exp 9", cyc); else n_pass++;
    n_chk++;
    if (nb !== 9) $display("FAIL basic_busy_cycles got %0d exp 9", nb); else n_pass++;
    n_chk++;
    if ({bout8, diff8} !== e) $display("FAIL basic_result got %h exp %h", {bout8, diff8}, e); else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({busy8, done8} !== 2'b00) $display("FAIL basic_after_done got busy/done=%b exp 00", {busy8, done8});
    else n_pass++;
  endtask

  task automatic test_vectors;
    bit found; int cyc, nb; logic [8:0] e;
    logic [16:0] vec[3] = '{{8'd3, 8'd5, 1'b0}, {8'd0, 8'd0, 1'b1}, {8'hFF, 8'hFF, 1'b0}};
    foreach (vec[i]) begin
      launch8(vec[i][16:9], vec[i][8:1], vec[i][0]);
      wait_done(1'b0, 1'b1, found, cyc, nb);
      n_chk++;
      if (!found) $display("FAIL vec%0d_timeout got no done exp done", i);
      else begin
        e = sb8.pop_front();
        if ({bout8, diff8} !== e) $display("FAIL vec%0d_result got %h exp %h", i, {bout8, diff8}, e);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    bit found; int cyc, nb; logic [8:0] e;
    launch8(8'd10, 8'd4, 1'b0);
    wait_done(1'b0, 1'b0, found, cyc, nb);
    n_chk++;
    if (!found) begin $display("FAIL b2b_first_timeout got no done exp done"); start8 = 1'b0; return; end
    e = sb8.pop_front();
    if ({bout8, diff8} !== e) $display("FAIL b2b_first got %h exp %h", {bout8, diff8}, e); else n_pass++;
    sb8.push_back(ref8(8'd10, 8'd4, 1'b0));
    repeat (4) @(negedge clk);
    a8 = 8'd1; b8 = 8'd2;
    wait_done(1'b0, 1'b0, found, cyc, nb);
    n_chk++;
    if (!found) begin $display("FAIL b2b_second_timeout got no done exp done"); start8 = 1'b0; return; end
    else if (cyc + 4 !== 10) $display("FAIL b2b_period got %0d exp 10", cyc + 4); else n_pass++;
    e = sb8.pop_front();
    n_chk++;
    if ({bout8, diff8} !== e) $display("FAIL b2b_mid_run_change got %h exp %h", {bout8, diff8}, e); else n_pass++;
    sb8.push_back(ref8(8'd1, 8'd2, 1'b0));
    wait_done(1'b0, 1'b0, found, cyc, nb);
    start8 = 1'b0;
    n_chk++;
    if (!found) $display("FAIL b2b_third_timeout got no done exp done");
    else begin
      e = sb8.pop_front();
      if ({bout8, diff8} !== e || cyc !== 10)
        $display("FAIL b2b_third got %h/%0d exp %h/10", {bout8, diff8}, cyc, e);
      else n_pass++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort;
    bit found; int cyc, nb; logic [8:0] e; logic [8:0] dropped; int spurious = 0;
    launch8(8'd200, 8'd100, 1'b0);
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    dropped = sb8.pop_front();
    n_chk++;
    if ({busy8, done8, diff8, bout8} !== 11'd0)
      $display("FAIL abort_async_clear got busy=%b done=%b diff=%h bout=%b exp all 0 (dropped %h)",
               busy8, done8, diff8, bout8, dropped);
    else n_pass++;
    repeat (2) begin @(negedge clk); if (done8) spurious++; end
    rst = 1'b0;
    repeat (12) begin @(negedge clk); if (done8) spurious++; end
    n_chk++;
    if (spurious !== 0) $display("FAIL abort_no_done got %0d done pulses exp 0", spurious); else n_pass++;
    launch8(8'd200, 8'd100, 1'b0);
    wait_done(1'b0, 1'b1, found, cyc, nb);
    n_chk++;
    if (!found) $display("FAIL abort_restart_timeout got no done exp done");
    else begin
      e = sb8.pop_front();
      if ({bout8, diff8} !== e || cyc !== 9)
        $display("FAIL abort_restart got %h/%0d exp %h/9", {bout8, diff8}, cyc, e);
      else n_pass++;
    end
  endtask

  task automatic test_idle_stable;
    logic [8:0] held = ref8(8'd200, 8'd100, 1'b0);
    int bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (done8 || busy8 || {bout8, diff8} !== held) bad++;
    end
    n_chk++;
    if (bad !== 0) $display("FAIL idle_stable got %0d bad cycles (last %h) exp 0 (%h)", bad, {bout8, diff8}, held);
    else n_pass++;
  endtask

  task automatic test_exhaustive4;
    bit found; int cyc, nb; logic [4:0] e; int extra = 0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          launch4(4'(x), 4'(y), 1'(c));
          wait_done(1'b1, 1'b1, found, cyc, nb);
          n_chk++;
          if (!found) $display("FAIL ex4_timeout a=%0d b=%0d bin=%0d got no done exp done", x, y, c);
          else begin
            e = sb4.pop_front();
            if ({bout4, diff4} !== e || cyc !== 5)
              $display("FAIL ex4 a=%0d b=%0d bin=%0d got %h/%0d exp %h/5", x, y, c, {bout4, diff4}, cyc, e);
            else n_pass++;
          end
          @(negedge clk);
          if (done4) extra++;
        end
    n_chk++;
    if (extra !== 0) $display("FAIL ex4_single_done got %0d extra pulses exp 0", extra); else n_pass++;
    n_chk++;
    if (sb4.size() !== 0) $display("FAIL ex4_scoreboard_drain got %0d left exp 0", sb4.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
    test_idle_stable();
    test_exhaustive4();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
